// File: rtl/sync_fifo_param_if.sv
// Handshake/bus bundle for sync_fifo_param.
// master: the producer/consumer logic driving requests; slave: the FIFO itself.
interface sync_fifo_param_if #(
  parameter int unsigned FIFO_SIZE  = 16,
  parameter int unsigned LOGIC_SIZE = 8
);
  localparam int unsigned CW = $clog2(FIFO_SIZE) + 1;

  logic                  i_wr;
  logic [LOGIC_SIZE-1:0] i_wdata;
  logic                  o_wfull;
  logic                  o_walmost_full;
  logic                  i_rr;
  logic [LOGIC_SIZE-1:0] o_rdata;
  logic                  o_rvalid;
  logic                  o_rempty;
  logic                  o_ralmost_empty;
  logic [CW-1:0]         o_count;
  logic                  i_err_clr;
  logic                  o_overflow;
  logic                  o_underflow;

  modport master (
    output i_wr, i_wdata, i_rr, i_err_clr,
    input  o_wfull, o_walmost_full, o_rdata, o_rvalid, o_rempty,
           o_ralmost_empty, o_count, o_overflow, o_underflow
  );

  modport slave (
    input  i_wr, i_wdata, i_rr, i_err_clr,
    output o_wfull, o_walmost_full, o_rdata, o_rvalid, o_rempty,
           o_ralmost_empty, o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with fill count, almost-full/empty flags and
// selectable FWFT or registered-read output.
// Optional sticky overflow/underflow flags: define SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo_param #(
  parameter int unsigned FIFO_SIZE     = 16,
  parameter int unsigned LOGIC_SIZE    = 8,
  parameter int unsigned FWFT          = 0,
  parameter int unsigned AFULL_THRESH  = FIFO_SIZE - 2,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  sync_fifo_param_if.slave  bus
);
  localparam int unsigned AW = $clog2(FIFO_SIZE);
  localparam int unsigned CW = AW + 1;

  logic [LOGIC_SIZE-1:0] mem [FIFO_SIZE];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_nxt;
  logic                  wfull_q;
  logic                  rempty_q;
  logic                  afull_q;
  logic                  aempty_q;
  logic                  wr_acc;
  logic                  rd_acc;

  // Acceptance is decided by the registered flags only; no same-cycle bypass.
  always_comb begin
    wr_acc    = bus.i_wr & ~wfull_q;
    rd_acc    = bus.i_rr & ~rempty_q;
    count_nxt = count_q;
    if (wr_acc && !rd_acc) begin
      count_nxt = count_q + CW'(1);
    end else if (!wr_acc && rd_acc) begin
      count_nxt = count_q - CW'(1);
    end
  end

  // Pointers, occupancy and the flags derived from the next occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q  <= count_nxt;
      wfull_q  <= (count_nxt == CW'(FIFO_SIZE));
      rempty_q <= (count_nxt == '0);
      afull_q  <= (count_nxt >= CW'(AFULL_THRESH));
      aempty_q <= (count_nxt <= CW'(AEMPTY_THRESH));
    end
  end

  // Storage array; contents are not reset, only the pointers are.
  always_ff @(posedge i_clk) begin
    if (wr_acc) mem[wr_ptr_q] <= bus.i_wdata;
  end

  assign bus.o_wfull         = wfull_q;
  assign bus.o_rempty        = rempty_q;
  assign bus.o_walmost_full  = afull_q;
  assign bus.o_ralmost_empty = aempty_q;
  assign bus.o_count         = count_q;

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry shown directly; forced to 0 while empty so reset reads 0.
      assign bus.o_rdata  = rempty_q ? '0 : mem[rd_ptr_q];
      assign bus.o_rvalid = ~rempty_q;
    end else begin : g_reg_read
      logic [LOGIC_SIZE-1:0] rdata_q;
      logic                  rvalid_q;

      // Registered read: data one cycle after an accepted pop, held otherwise.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= rd_acc;
          if (rd_acc) rdata_q <= mem[rd_ptr_q];
        end
      end

      assign bus.o_rdata  = rdata_q;
      assign bus.o_rvalid = rvalid_q;
    end
  endgenerate

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  // Sticky error flags; a set event wins over a same-cycle clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.i_wr && wfull_q) begin
        overflow_q <= 1'b1;
      end else if (bus.i_err_clr) begin
        overflow_q <= 1'b0;
      end
      if (bus.i_rr && rempty_q) begin
        underflow_q <= 1'b1;
      end else if (bus.i_err_clr) begin
        underflow_q <= 1'b0;
      end
    end
  end

  assign bus.o_overflow  = overflow_q;
  assign bus.o_underflow = underflow_q;
`else
  assign bus.o_overflow  = 1'b0;
  assign bus.o_underflow = 1'b0;
`endif

endmodule
